// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the framebuffer arbiter: owner tags for the
// read-return pipeline, the fixed read latency and the default bus widths.
package vga_fb_pkg;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 8;

  // Request cycle to rvalid cycle; the RAM itself contributes one cycle.
  localparam int RD_LATENCY = 3;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_HOST_RD
  } owner_e;

endpackage

// File: rtl/vga_fb_starve_mon.sv
// Host starvation monitor: counts consecutive wait cycles (saturating) and
// raises a sticky flag at the limit until the host is next served.
module vga_fb_starve_mon #(
  parameter int STARVE_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_cycle,
  input  logic served,
  output logic starved
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      starved <= 1'b0;
    end else begin
      // Any non-wait cycle (served, or the host withdrew) restarts the count.
      if (wait_cycle) begin
        if (cnt != LIMIT) cnt <= cnt + 1'b1;
        if (cnt >= LIMIT - 1'b1) starved <= 1'b1;
      end else begin
        cnt <= '0;
      end
      if (served) starved <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Fixed-priority arbiter sharing one single-port framebuffer RAM between the
// VGA pixel fetch (always wins) and a host read/write port.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Tag stages between issue and return; the last stage lines up with mem_rdata.
  localparam int TAG_STAGES = RD_LATENCY - 1;
  localparam int TAG_LAST   = TAG_STAGES - 1;

  owner_e tag_pipe [TAG_STAGES];

  // Host is accepted only in cycles the display leaves idle.
  assign host_ready = host_valid & ~disp_req & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      for (int i = 0; i < TAG_STAGES; i++) tag_pipe[i] <= OWN_NONE;
    end else begin
      if (disp_req) begin
        mem_en      <= 1'b1;
        mem_we      <= 1'b0;
        mem_addr    <= disp_addr;
        tag_pipe[0] <= OWN_DISP;
      end else if (host_ready) begin
        mem_en      <= 1'b1;
        mem_we      <= host_we;
        mem_addr    <= host_addr;
        mem_wdata   <= host_wdata;
        tag_pipe[0] <= host_we ? OWN_NONE : OWN_HOST_RD;
      end else begin
        // Address and write data hold so the RAM bus stays quiet when idle.
        mem_en      <= 1'b0;
        mem_we      <= 1'b0;
        tag_pipe[0] <= OWN_NONE;
      end

      for (int i = 1; i < TAG_STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];

      disp_rvalid <= (tag_pipe[TAG_LAST] == OWN_DISP);
      host_rvalid <= (tag_pipe[TAG_LAST] == OWN_HOST_RD);
      if (tag_pipe[TAG_LAST] == OWN_DISP)    disp_rdata <= mem_rdata;
      if (tag_pipe[TAG_LAST] == OWN_HOST_RD) host_rdata <= mem_rdata;
    end
  end

  vga_fb_starve_mon #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_mon (
    .clk       (clk),
    .rst       (rst),
    .wait_cycle(host_valid & ~host_ready),
    .served    (host_ready),
    .starved   (host_starved)
  );

endmodule
